// File: rtl/serial_pkg.sv
// Shared encodings and defaults for the bit-serial adder sequencer.
package serial_pkg;

    localparam int SER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load, right-shift register; serial input enters at the MSB.
// Load and shift take effect on the next edge; load has priority over shift.
module serial_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (shift_en) begin
            r_q <= {si, r_q[WIDTH-1:1]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: loads operands, shifts WIDTH bits LSB first, reports sum/carry.
// done follows an accept by WIDTH+1 cycles; start outside IDLE is dropped, not queued.
module serial_add_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             shift_cont,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_s;
    logic             w_cy;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_shift  = (r_state == ST_SHIFT);
    assign w_last   = (r_count == CW'(WIDTH - 1));
    assign w_s      = w_a[0] ^ w_b[0] ^ r_carry;
    assign w_cy     = (w_a[0] & w_b[0]) | (r_carry & (w_a[0] ^ w_b[0]));

    // In accumulate mode A keeps the previous sum and only B is reloaded.
    serial_shift_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clock    (clock),
        .reset    (reset),
        .load     (w_accept && !accumulate),
        .shift_en (w_shift),
        .d        (op_a),
        .si       (w_s),
        .q        (w_a)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clock    (clock),
        .reset    (reset),
        .load     (w_accept),
        .shift_en (w_shift),
        .d        (op_b),
        .si       (1'b0),
        .q        (w_b)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next = start  ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_next = w_last ? ST_DONE  : ST_SHIFT;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_cont = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                shift_cont = 1'b1;
                busy       = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (w_shift) begin
            r_count <= r_count + CW'(1);
            r_carry <= w_cy;
        end
    end

    assign sum       = w_a;
    assign carry_out = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=4: vector table plus multi-cycle corner sequences.
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic         start;
    logic         accumulate;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         shift_cont;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         acc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_c;
    } vec_t;

    vec_t vecs[6];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .accumulate (accumulate),
        .op_a       (op_a),
        .op_b       (op_b),
        .shift_cont (shift_cont),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .carry_out  (carry_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts one operation from IDLE and checks every cycle through to the return to IDLE.
    task automatic run_op(input string name, input logic acc, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_sum,
                          input logic exp_c);
        start = 1'b1; accumulate = acc; op_a = a; op_b = b;
        step();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check({name, " shift_cont"}, shift_cont, 1);
            check({name, " busy"}, busy, 1);
            check({name, " no early done"}, done, 0);
            op_a = ~a; op_b = ~b; accumulate = ~acc;
            step();
        end
        check({name, " done"}, done, 1);
        check({name, " shift_cont in done"}, shift_cont, 0);
        check({name, " sum"}, sum, exp_sum);
        check({name, " carry"}, carry_out, exp_c);
        step();
        check({name, " done pulse width"}, done, 0);
        check({name, " idle busy"}, busy, 0);
        check({name, " idle sum hold"}, sum, exp_sum);
        check({name, " idle carry hold"}, carry_out, exp_c);
        accumulate = 1'b0;
    endtask

    initial begin
        int dcnt;

        vecs[0] = '{acc: 1'b0, a: 4'd5,  b: 4'd3, exp_sum: 4'd8,  exp_c: 1'b0};
        vecs[1] = '{acc: 1'b0, a: 4'd9,  b: 4'd9, exp_sum: 4'd2,  exp_c: 1'b1};
        vecs[2] = '{acc: 1'b0, a: 4'd15, b: 4'd1, exp_sum: 4'd0,  exp_c: 1'b1};
        vecs[3] = '{acc: 1'b0, a: 4'd5,  b: 4'd3, exp_sum: 4'd8,  exp_c: 1'b0};
        vecs[4] = '{acc: 1'b1, a: 4'd2,  b: 4'd7, exp_sum: 4'd15, exp_c: 1'b0};
        vecs[5] = '{acc: 1'b1, a: 4'd9,  b: 4'd1, exp_sum: 4'd0,  exp_c: 1'b1};

        reset = 1'b1; start = 1'b1; accumulate = 1'b0; op_a = 4'd5; op_b = 4'd3;
        step();
        step();
        check("reset shift_cont", shift_cont, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset carry", carry_out, 0);
        reset = 1'b0; start = 1'b0;
        step();
        check("idle hold sum", sum, 0);
        check("idle hold busy", busy, 0);

        for (int v = 0; v < 6; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].acc, vecs[v].a, vecs[v].b,
                   vecs[v].exp_sum, vecs[v].exp_c);
            step();
        end

        // Accumulate straight after reset adds to zero.
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_op("acc after reset", 1'b1, 4'd9, 4'd6, 4'd6, 1'b0);

        // Start pulses in SHIFT cycles 2 and 4 and in DONE are dropped.
        start = 1'b1; op_a = 4'd2; op_b = 4'd3;
        step();
        dcnt = 0;
        for (int j = 1; j <= 12; j++) begin
            start = (j == 2 || j == 4 || j == 5);
            op_a = 4'd7; op_b = 4'd7;
            step();
            if (done) dcnt++;
        end
        start = 1'b0;
        check("ignored start: done count", dcnt, 1);
        check("ignored start: sum", sum, 5);
        check("ignored start: busy", busy, 0);

        // Reset on the second SHIFT cycle aborts the operation.
        start = 1'b1; op_a = 4'd5; op_b = 4'd6;
        step();
        start = 1'b0;
        step();
        check("abort pre busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort sum", sum, 0);
        check("abort carry", carry_out, 0);
        check("abort done", done, 0);
        dcnt = 0;
        for (int j = 0; j < 8; j++) begin
            if (done) dcnt++;
            step();
        end
        check("abort no done", dcnt, 0);
        run_op("after abort", 1'b0, 4'd6, 4'd6, 4'd12, 1'b0);

        // start held high: one accept per W+2 cycles, mid-SHIFT op_a changes ignored.
        start = 1'b1; op_a = 4'd1; op_b = 4'd2;
        step();
        dcnt = 0;
        for (int j = 0; j < 18; j++) begin
            check($sformatf("held start done @%0d", j), done, ((j % 6) == 4) ? 1 : 0);
            if (done) begin
                dcnt++;
                check($sformatf("held start sum @%0d", j), sum, 3);
                check($sformatf("held start carry @%0d", j), carry_out, 0);
            end
            op_a = ((j % 6) >= 0 && (j % 6) <= 2) ? 4'd9 : 4'd1;
            step();
        end
        start = 1'b0;
        check("held start done count", dcnt, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
